memory_access_stage: RTL and testbench
======================================

# memory_access_stage

Pipeline MEM stage: consumes EX/MEM fields and drives the MEM/WB register. It performs MIPS loads and stores over a single-outstanding req/ack data bus, does byte-lane steering and sign/zero extension, and detects misaligned-address and bus-timeout exceptions. While an access is in flight it holds upstream via `mem_busy`.

## Interface
- `TIMEOUT`, default 255: WAIT cycles without `dbus_ack` before a bus error is raised (≥1).
- `clk` in 1: clock.
- `rst` in 1: synchronous, active-high reset.
- `stall_in` in 1: global stall from the hazard unit; holds MEM/WB.
- `flush` in 1: clears MEM/WB and cancels the current access.
- `ex_valid` in 1: EX/MEM entry valid.
- `ex_pc` in 32: instruction PC.
- `ex_mem_op` in 4: 0 none, 1 LB, 2 LBU, 3 LH, 4 LHU, 5 LW, 6 SB, 7 SH, 8 SW; 9–15 treated as none.
- `ex_addr` in 32: effective address (ALU result).
- `ex_store_data` in 32: forwarded rt.
- `ex_reg_write_en` in 1, `ex_reg_write_addr` in 5, `ex_reg_write_data` in 32: writeback request from EX.
- `ex_exception` in 4: upstream exception code; 0 means none.
- `dbus_req` out 1: access request, registered.
- `dbus_we` out 1: 1 for store.
- `dbus_addr` out 32: `{addr[31:2],2'b00}`.
- `dbus_byte_en` out 4: lane enables.
- `dbus_wdata` out 32: lane-replicated store data.
- `dbus_ack` in 1: completion, single-cycle pulse.
- `dbus_rdata` in 32: read data, valid with `dbus_ack`.
- `mem_busy` out 1: combinational; stalls IF/ID/EX.
- `wb_valid` out 1, `wb_pc` out 32, `wb_reg_write_en` out 1, `wb_reg_write_addr` out 5, `wb_reg_write_data` out 32, `wb_exception` out 4, `wb_bad_vaddr` out 32: MEM/WB register.

## Operation
- **Exception codes:** 4 ADDR_LOAD, 5 ADDR_STORE, 6 BUS_ERROR. An upstream `ex_exception`≠0 takes precedence over all of them.
- **Misalignment:** LH/LHU/SH require `addr[0]`=0. LW/SW require `addr[1:0]`=0. A misaligned access raises 4 (load) or 5 (store), sets `wb_bad_vaddr`=`ex_addr`, and issues no bus access.
- **Access start:** `access_start = ex_valid & op∈1..8 & ex_exception==0 & aligned & !flush`.
- **FSM states:** IDLE, WAIT, DONE.
  - IDLE → WAIT on `access_start`. On the same edge, latch `dbus_addr`, `dbus_we`, `dbus_byte_en`, `dbus_wdata`, and set `dbus_req`=1. Clear the timeout counter.
  - WAIT: bus outputs are held constant. On `dbus_ack`: `dbus_req`←0, capture `dbus_rdata` into `rdata_q`, go to DONE. If the counter reaches `TIMEOUT` first: `dbus_req`←0, set `bus_err_q`, go to DONE.
  - DONE: wait while `stall_in`=1; go to IDLE when `stall_in`=0. DONE is the only state in which the access result enters MEM/WB, so the same access is never reissued.
- **`mem_busy`** = (IDLE & `access_start`) | WAIT. It does not depend on `stall_in`, so there is no combinational loop.
- **Flush in WAIT:** set `cancel_q`. `dbus_req` stays high until ack or timeout (a transaction is never abandoned). The FSM then goes directly to IDLE, discards the result, and MEM/WB stays as cleared by the flush. Flush in DONE: go to IDLE.
- **Store lanes:**
  - SB: `byte_en = 1<<addr[1:0]`, `wdata = {4{d[7:0]}}`.
  - SH: `byte_en = addr[1] ? 1100 : 0011`, `wdata = {2{d[15:0]}}`.
  - SW: `byte_en = 1111`.
  - Loads: `byte_en = 1111`.
- **Load extract** (little-endian, from `rdata_q`): lane select by `addr[1:0]` / `addr[1]`. LB/LH sign-extend; LBU/LHU zero-extend.
- **MEM/WB update:** `rst|flush` clears every field to 0. Otherwise, `mem_busy|stall_in` holds. Otherwise the register loads:
  - `wb_valid`=`ex_valid`.
  - `wb_pc`, `wb_reg_write_addr` from the inputs.
  - `wb_exception` = final code (with `bus_err_q` giving 6, `wb_bad_vaddr`=`ex_addr`).
  - `wb_reg_write_data` = extracted load data for loads, else `ex_reg_write_data`.
  - `wb_reg_write_en` = `ex_reg_write_en` & (final exception==0).
- Non-memory ops and faulting ops pass through from IDLE in one cycle.

## Timing
- **Reset:** all outputs 0 (including `dbus_*`, `mem_busy` when `ex_valid`=0, and all `wb_*`). FSM in IDLE; `cancel_q`, `bus_err_q`, `rdata_q` and the counter are all 0.
- **Zero-wait load,** detected in cycle 0:
  - Cycle 0: `mem_busy`=1.
  - Cycle 1: `dbus_req`=1 and ack arrives; `mem_busy`=1.
  - Cycle 2: DONE, `mem_busy`=0.
  - Cycle 3: `wb_*` visible.
  - Each extra ack wait cycle adds 1.
- **Timeout:** `dbus_req` is high for exactly `TIMEOUT` cycles.
- **Ack in IDLE or DONE** is ignored.
- **`rst` mid-WAIT** returns to IDLE and drops `dbus_req` on the next edge.

## Test plan
- Non-memory op: `ex_reg_write_data`=0x1234, no stall → `wb_reg_write_data`=0x1234 one cycle later; `mem_busy` stays 0.
- LB with `addr`=0x1003, `rdata`=0x80FF_FFFF, ack after 2 wait cycles → `wb_reg_write_data`=0xFFFF_FF80 and `mem_busy` high for 3 cycles. LBU with the same data → 0x0000_0080.
- SH with `addr`=0x2002, `d`=0xABCD_1234 → `dbus_addr`=0x2000, `byte_en`=1100, `wdata`=0x1234_1234, `we`=1; `wb_reg_write_en`=0.
- LW at 0x2001 → no `dbus_req`, `wb_exception`=4, `wb_bad_vaddr`=0x2001, `wb_reg_write_en`=0. The same case with `ex_exception`=12 → `wb_exception`=12.
- `TIMEOUT`=4, no ack → `dbus_req` high 4 cycles, then `wb_exception`=6.
- Flush in WAIT → `dbus_req` is held until ack, then the FSM returns to IDLE, `wb_valid`=0, and no reissue occurs. `stall_in` high 3 cycles in DONE → only one bus access.

Source files
------------

// File: rtl/memory_access_stage.sv
// MEM pipeline stage: MIPS loads/stores over a single-outstanding req/ack bus,
// lane steering, load extension, alignment and bus-timeout exceptions.
//
// state | meaning
// IDLE  | no access in flight; pass-through ops and faulting ops retire here
// WAIT  | request on the bus, waiting for ack or timeout
// DONE  | access finished; result enters MEM/WB when stall_in drops
module memory_access_stage #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_in,
    input  logic        flush,
    input  logic        ex_valid,
    input  logic [31:0] ex_pc,
    input  logic [3:0]  ex_mem_op,
    input  logic [31:0] ex_addr,
    input  logic [31:0] ex_store_data,
    input  logic        ex_reg_write_en,
    input  logic [4:0]  ex_reg_write_addr,
    input  logic [31:0] ex_reg_write_data,
    input  logic [3:0]  ex_exception,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_byte_en,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        mem_busy,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic        wb_reg_write_en,
    output logic [4:0]  wb_reg_write_addr,
    output logic [31:0] wb_reg_write_data,
    output logic [3:0]  wb_exception,
    output logic [31:0] wb_bad_vaddr
);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [3:0] OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3, OP_LHU = 4'd4,
                           OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;
    localparam logic [3:0] EXC_ADDR_LOAD = 4'd4, EXC_ADDR_STORE = 4'd5, EXC_BUS = 4'd6;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cancel_q, cancel_d, bus_err_q, bus_err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          req_q, req_d, we_q, we_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;

    logic        is_load, is_store, is_mem, misaligned, access_start;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, ld_data, wb_data_d, bad_vaddr_d;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [3:0]  exc_final;

    assign is_load  = (ex_mem_op >= OP_LB) && (ex_mem_op <= OP_LW);
    assign is_store = (ex_mem_op >= OP_SB) && (ex_mem_op <= OP_SW);
    assign is_mem   = is_load | is_store;
    assign misaligned = ((ex_mem_op == OP_LH || ex_mem_op == OP_LHU || ex_mem_op == OP_SH) && ex_addr[0])
                      | ((ex_mem_op == OP_LW || ex_mem_op == OP_SW) && (ex_addr[1:0] != 2'b00));
    assign access_start = ex_valid & is_mem & (ex_exception == 4'd0) & ~misaligned & ~flush;
    assign mem_busy = ((state_q == S_IDLE) & access_start) | (state_q == S_WAIT);

    always_comb begin
        lane_be    = 4'b1111;
        lane_wdata = ex_store_data;
        case (ex_mem_op)
            OP_SB: begin
                lane_be    = 4'b0001 << ex_addr[1:0];
                lane_wdata = {4{ex_store_data[7:0]}};
            end
            OP_SH: begin
                lane_be    = ex_addr[1] ? 4'b1100 : 4'b0011;
                lane_wdata = {2{ex_store_data[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        cancel_d  = cancel_q;
        bus_err_d = bus_err_q;
        rdata_d   = rdata_q;
        req_d     = req_q;
        we_d      = we_q;
        addr_d    = addr_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (access_start) begin
                    state_d   = S_WAIT;
                    req_d     = 1'b1;
                    we_d      = is_store;
                    addr_d    = {ex_addr[31:2], 2'b00};
                    be_d      = lane_be;
                    wdata_d   = lane_wdata;
                    cnt_d     = '0;
                    cancel_d  = 1'b0;
                    bus_err_d = 1'b0;
                end
            end
            S_WAIT: begin
                if (flush) cancel_d = 1'b1;
                // A flushed access still runs to completion, then its result is dropped.
                if (dbus_ack) begin
                    req_d    = 1'b0;
                    rdata_d  = dbus_rdata;
                    state_d  = (cancel_q | flush) ? S_IDLE : S_DONE;
                    cancel_d = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    req_d     = 1'b0;
                    bus_err_d = 1'b1;
                    state_d   = (cancel_q | flush) ? S_IDLE : S_DONE;
                    cancel_d  = 1'b0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                if (flush | ~stall_in) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        case (ex_addr[1:0])
            2'd0:    ld_byte = rdata_q[7:0];
            2'd1:    ld_byte = rdata_q[15:8];
            2'd2:    ld_byte = rdata_q[23:16];
            default: ld_byte = rdata_q[31:24];
        endcase
        ld_half = ex_addr[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (ex_mem_op)
            OP_LB:   ld_data = {{24{ld_byte[7]}}, ld_byte};
            OP_LBU:  ld_data = {24'd0, ld_byte};
            OP_LH:   ld_data = {{16{ld_half[15]}}, ld_half};
            OP_LHU:  ld_data = {16'd0, ld_half};
            default: ld_data = rdata_q;
        endcase
        wb_data_d = is_load ? ld_data : ex_reg_write_data;
    end

    always_comb begin
        exc_final   = 4'd0;
        bad_vaddr_d = 32'd0;
        if (ex_exception != 4'd0) begin
            exc_final = ex_exception;
        end else if (is_mem && misaligned) begin
            exc_final   = is_load ? EXC_ADDR_LOAD : EXC_ADDR_STORE;
            bad_vaddr_d = ex_addr;
        end else if (state_q == S_DONE && bus_err_q) begin
            exc_final   = EXC_BUS;
            bad_vaddr_d = ex_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            cancel_q  <= 1'b0;
            bus_err_q <= 1'b0;
            rdata_q   <= 32'd0;
            req_q     <= 1'b0;
            we_q      <= 1'b0;
            addr_q    <= 32'd0;
            be_q      <= 4'd0;
            wdata_q   <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            cancel_q  <= cancel_d;
            bus_err_q <= bus_err_d;
            rdata_q   <= rdata_d;
            req_q     <= req_d;
            we_q      <= we_d;
            addr_q    <= addr_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst | flush) begin
            wb_valid          <= 1'b0;
            wb_pc             <= 32'd0;
            wb_reg_write_en   <= 1'b0;
            wb_reg_write_addr <= 5'd0;
            wb_reg_write_data <= 32'd0;
            wb_exception      <= 4'd0;
            wb_bad_vaddr      <= 32'd0;
        end else if (!(mem_busy | stall_in)) begin
            wb_valid          <= ex_valid;
            wb_pc             <= ex_pc;
            wb_reg_write_en   <= ex_reg_write_en & (exc_final == 4'd0);
            wb_reg_write_addr <= ex_reg_write_addr;
            wb_reg_write_data <= wb_data_d;
            wb_exception      <= exc_final;
            wb_bad_vaddr      <= bad_vaddr_d;
        end
    end

    assign dbus_req     = req_q;
    assign dbus_we      = we_q;
    assign dbus_addr    = addr_q;
    assign dbus_byte_en = be_q;
    assign dbus_wdata   = wdata_q;
endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage with a TIMEOUT of 4.
module tb_memory_access_stage;
    logic        clk = 1'b0;
    logic        rst, stall_in, flush, ex_valid, ex_reg_write_en, dbus_ack;
    logic [31:0] ex_pc, ex_addr, ex_store_data, ex_reg_write_data, dbus_rdata;
    logic [3:0]  ex_mem_op, ex_exception;
    logic [4:0]  ex_reg_write_addr;
    logic        dbus_req, dbus_we, mem_busy, wb_valid, wb_reg_write_en;
    logic [31:0] dbus_addr, dbus_wdata, wb_pc, wb_reg_write_data, wb_bad_vaddr;
    logic [3:0]  dbus_byte_en, wb_exception;
    logic [4:0]  wb_reg_write_addr;

    int checks = 0;
    int errors = 0;
    int busy_cnt = 0;
    int acc_cnt = 0;
    int acc_base;
    int n;
    logic req_prev = 1'b0;

    memory_access_stage #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .stall_in(stall_in), .flush(flush),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_mem_op(ex_mem_op), .ex_addr(ex_addr),
        .ex_store_data(ex_store_data), .ex_reg_write_en(ex_reg_write_en),
        .ex_reg_write_addr(ex_reg_write_addr), .ex_reg_write_data(ex_reg_write_data),
        .ex_exception(ex_exception),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr),
        .dbus_byte_en(dbus_byte_en), .dbus_wdata(dbus_wdata),
        .dbus_ack(dbus_ack), .dbus_rdata(dbus_rdata), .mem_busy(mem_busy),
        .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_reg_write_en(wb_reg_write_en),
        .wb_reg_write_addr(wb_reg_write_addr), .wb_reg_write_data(wb_reg_write_data),
        .wb_exception(wb_exception), .wb_bad_vaddr(wb_bad_vaddr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_busy) busy_cnt++;
        if (dbus_req && !req_prev) acc_cnt++;
        req_prev = dbus_req;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_op(input logic [3:0] op, input logic [31:0] addr, input logic we);
        ex_valid = 1'b1;
        ex_mem_op = op;
        ex_addr = addr;
        ex_reg_write_en = we;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; stall_in = 1'b0; flush = 1'b0; ex_valid = 1'b0; ex_pc = 32'd0;
        ex_mem_op = 4'd0; ex_addr = 32'd0; ex_store_data = 32'd0; ex_reg_write_en = 1'b0;
        ex_reg_write_addr = 5'd0; ex_reg_write_data = 32'd0; ex_exception = 4'd0;
        dbus_ack = 1'b0; dbus_rdata = 32'd0;
        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_req", dbus_req, 0);
        chk("rst_we", dbus_we, 0);
        chk("rst_addr", dbus_addr, 0);
        chk("rst_be", dbus_byte_en, 0);
        chk("rst_wdata", dbus_wdata, 0);
        chk("rst_busy", mem_busy, 0);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_wb_data", wb_reg_write_data, 0);
        chk("rst_wb_exc", wb_exception, 0);

        // non-memory pass-through
        tick();
        set_op(4'd0, 32'd5, 1'b1);
        ex_pc = 32'h100; ex_reg_write_addr = 5'd2; ex_reg_write_data = 32'h1234;
        #1 chk("nonmem_busy", mem_busy, 0);
        tick();
        ex_valid = 1'b0;
        #1;
        chk("nonmem_data", wb_reg_write_data, 32'h1234);
        chk("nonmem_valid", wb_valid, 1);
        chk("nonmem_we", wb_reg_write_en, 1);
        chk("nonmem_pc", wb_pc, 32'h100);
        chk("nonmem_req", dbus_req, 0);

        // LB at 0x1003, ack on the second wait cycle
        tick();
        set_op(4'd1, 32'h1003, 1'b1);
        ex_pc = 32'h104; ex_reg_write_addr = 5'd3; ex_reg_write_data = 32'h0;
        busy_cnt = 0;
        #1 chk("lb_busy0", mem_busy, 1);
        tick();
        chk("lb_req", dbus_req, 1);
        chk("lb_addr", dbus_addr, 32'h1000);
        chk("lb_be", dbus_byte_en, 4'b1111);
        chk("lb_we", dbus_we, 0);
        tick();
        dbus_ack = 1'b1; dbus_rdata = 32'h80FF_FFFF;
        tick();
        dbus_ack = 1'b0;
        #1 chk("lb_done_busy", mem_busy, 0);
        chk("lb_done_req", dbus_req, 0);
        tick();
        ex_valid = 1'b0;
        #1;
        chk("lb_data", wb_reg_write_data, 32'hFFFF_FF80);
        chk("lb_valid", wb_valid, 1);
        chk("lb_wb_addr", wb_reg_write_addr, 5'd3);
        chk("lb_busy_cycles", busy_cnt, 3);

        // LBU, same data, zero-wait ack
        tick();
        set_op(4'd2, 32'h1003, 1'b1);
        tick();
        dbus_ack = 1'b1; dbus_rdata = 32'h80FF_FFFF;
        tick();
        dbus_ack = 1'b0;
        tick();
        ex_valid = 1'b0;
        #1 chk("lbu_data", wb_reg_write_data, 32'h0000_0080);

        // SH at 0x2002
        tick();
        set_op(4'd7, 32'h2002, 1'b0);
        ex_store_data = 32'hABCD_1234;
        tick();
        chk("sh_req", dbus_req, 1);
        chk("sh_addr", dbus_addr, 32'h2000);
        chk("sh_be", dbus_byte_en, 4'b1100);
        chk("sh_wdata", dbus_wdata, 32'h1234_1234);
        chk("sh_we", dbus_we, 1);
        dbus_ack = 1'b1;
        tick();
        dbus_ack = 1'b0;
        tick();
        ex_valid = 1'b0;
        #1;
        chk("sh_wb_we", wb_reg_write_en, 0);
        chk("sh_wb_valid", wb_valid, 1);

        // misaligned LW, then with an upstream exception, then misaligned SW
        tick();
        acc_base = acc_cnt;
        set_op(4'd5, 32'h2001, 1'b1);
        #1 chk("lwmis_busy", mem_busy, 0);
        tick();
        chk("lwmis_exc", wb_exception, 4'd4);
        chk("lwmis_bad", wb_bad_vaddr, 32'h2001);
        chk("lwmis_we", wb_reg_write_en, 0);
        chk("lwmis_req", dbus_req, 0);
        ex_exception = 4'd12;
        tick();
        chk("lwup_exc", wb_exception, 4'd12);
        ex_exception = 4'd0;
        set_op(4'd8, 32'h2002, 1'b0);
        tick();
        chk("swmis_exc", wb_exception, 4'd5);
        chk("mis_no_access", acc_cnt, acc_base);
        ex_valid = 1'b0;

        // timeout: no ack
        tick();
        set_op(4'd5, 32'h3000, 1'b1);
        tick();
        n = 0;
        while (dbus_req === 1'b1 && n < 20) begin
            n++;
            tick();
        end
        chk("to_req_cycles", n, 4);
        chk("to_done_busy", mem_busy, 0);
        tick();
        ex_valid = 1'b0;
        #1;
        chk("to_exc", wb_exception, 4'd6);
        chk("to_bad", wb_bad_vaddr, 32'h3000);
        chk("to_we", wb_reg_write_en, 0);

        // flush while waiting
        tick();
        ex_reg_write_data = 32'h5555;
        set_op(4'd5, 32'h4000, 1'b1);
        acc_base = acc_cnt;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0; ex_valid = 1'b0; ex_mem_op = 4'd0;
        #1;
        chk("fl_req_held", dbus_req, 1);
        chk("fl_wb_valid", wb_valid, 0);
        tick();
        chk("fl_req_held2", dbus_req, 1);
        dbus_ack = 1'b1; dbus_rdata = 32'hDEAD_BEEF;
        tick();
        dbus_ack = 1'b0;
        #1;
        chk("fl_req_drop", dbus_req, 0);
        chk("fl_busy", mem_busy, 0);
        tick();
        tick();
        chk("fl_no_reissue", acc_cnt, acc_base + 1);
        chk("fl_wb_exc", wb_exception, 0);

        // stall held for three DONE cycles
        tick();
        set_op(4'd5, 32'h5000, 1'b1);
        ex_reg_write_addr = 5'd7;
        acc_base = acc_cnt;
        tick();
        dbus_ack = 1'b1; dbus_rdata = 32'h1122_3344; stall_in = 1'b1;
        tick();
        dbus_ack = 1'b0;
        #1;
        chk("st_busy", mem_busy, 0);
        chk("st_wb_held", wb_valid, 0);
        tick();
        tick();
        stall_in = 1'b0;
        tick();
        ex_valid = 1'b0;
        #1;
        chk("st_data", wb_reg_write_data, 32'h1122_3344);
        chk("st_valid", wb_valid, 1);
        tick();
        tick();
        chk("st_one_access", acc_cnt, acc_base + 1);

        // reset in the middle of WAIT
        tick();
        set_op(4'd5, 32'h6000, 1'b1);
        tick();
        chk("rw_req", dbus_req, 1);
        rst = 1'b1; ex_valid = 1'b0;
        tick();
        chk("rw_req_drop", dbus_req, 0);
        chk("rw_busy", mem_busy, 0);
        chk("rw_wb_valid", wb_valid, 0);
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
